// File: rtl/cpu_core_p.sv
// Two-word-instruction accumulator CPU with a parametric data width and a memory
// bus that uses a ready handshake, so slow memories can insert wait states.
module cpu_core_p #(
    parameter int DATA_W   = 8,
    parameter int RESET_PC = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ready,
    input  logic [DATA_W-1:0]   data_in,
    output logic [DATA_W-1:0]   data_out,
    output logic                data_oe,
    output logic [2*DATA_W-4:0] addr,
    output logic                rd,
    output logic                wr,
    output logic                halt,
    output logic [DATA_W-1:0]   acc,
    output logic                zero
);
    localparam int ADDR_W = 2*DATA_W - 3;
    localparam logic [ADDR_W-1:0] RESET_PC_A = ADDR_W'(RESET_PC);

    localparam logic [2:0] OP_HLT = 3'b000;
    localparam logic [2:0] OP_SKZ = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_LDA = 3'b101;
    localparam logic [2:0] OP_STO = 3'b110;
    localparam logic [2:0] OP_JMP = 3'b111;

    typedef enum logic [2:0] {
        S_IF0  = 3'd0,
        S_IF1  = 3'd1,
        S_EX   = 3'd2,
        S_MRD  = 3'd3,
        S_MWR  = 3'd4,
        S_HALT = 3'd5
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [2*DATA_W-1:0] ir_q, ir_d;
    logic [DATA_W-1:0]   acc_q, acc_d;

    logic [2:0]          opc;
    logic [ADDR_W-1:0]   op_addr;
    logic [DATA_W-1:0]   alu;
    logic                acc_zero;

    assign opc      = ir_q[2*DATA_W-1 -: 3];
    assign op_addr  = ir_q[ADDR_W-1:0];
    assign acc_zero = (acc_q == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IF0;
            pc_q    <= RESET_PC_A;
            ir_q    <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            acc_q   <= acc_d;
        end
    end

    always_comb begin
        alu = data_in;
        case (opc)
            OP_ADD:  alu = acc_q + data_in;
            OP_AND:  alu = acc_q & data_in;
            OP_XOR:  alu = acc_q ^ data_in;
            default: alu = data_in;
        endcase
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        acc_d   = acc_q;
        case (state_q)
            S_IF0: begin
                if (ready) begin
                    ir_d[2*DATA_W-1:DATA_W] = data_in;
                    pc_d                    = pc_q + ADDR_W'(1);
                    state_d                 = S_IF1;
                end
            end
            S_IF1: begin
                if (ready) begin
                    ir_d[DATA_W-1:0] = data_in;
                    pc_d             = pc_q + ADDR_W'(1);
                    state_d          = S_EX;
                end
            end
            S_EX: begin
                case (opc)
                    OP_HLT: state_d = S_HALT;
                    OP_SKZ: begin
                        if (acc_zero) pc_d = pc_q + ADDR_W'(2);
                        state_d = S_IF0;
                    end
                    OP_JMP: begin
                        pc_d    = op_addr;
                        state_d = S_IF0;
                    end
                    OP_STO:  state_d = S_MWR;
                    default: state_d = S_MRD;
                endcase
            end
            S_MRD: begin
                if (ready) begin
                    acc_d   = alu;
                    state_d = S_IF0;
                end
            end
            S_MWR: begin
                if (ready) state_d = S_IF0;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IF0;
        endcase
    end

    // Bus strobes are gated by reset so an in-flight access drops without a clock edge.
    always_comb begin
        rd   = reset && (state_q == S_IF0 || state_q == S_IF1 || state_q == S_MRD);
        wr   = reset && (state_q == S_MWR);
        halt = (state_q == S_HALT);
        addr = pc_q;
        if (state_q == S_EX || state_q == S_MRD || state_q == S_MWR) addr = op_addr;
    end

    assign data_oe  = wr;
    assign data_out = acc_q;
    assign acc      = acc_q;
    assign zero     = acc_zero;

endmodule
